// File: rtl/cmp_pkg.sv
// Shared types and helpers for the streaming comparator (cmp_stream_pipe).
// Result encoding is a 3-bit one-hot {lt, gt, eq}.
package cmp_pkg;

    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_LT   = 3'b100;
    localparam cmp_res_t CMP_GT   = 3'b010;
    localparam cmp_res_t CMP_EQ   = 3'b001;
    localparam cmp_res_t CMP_NONE = 3'b000;

    // Increment val, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (val >= max_v) ? max_v : val + 32'd1;
    endfunction

endpackage

// File: rtl/cmp_stream_pipe_if.sv
// Stream bus for cmp_stream_pipe: operand handshake in, result handshake out.
// The stats signals exist only when CMP_STATS_EN is defined.
interface cmp_stream_pipe_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STRK_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              sgn;
    logic              out_valid;
    logic              out_ready;
    logic              lt;
    logic              gt;
    logic              eq;
    logic [STRK_W-1:0] streak;
`ifdef CMP_STATS_EN
    logic              stat_clr;
    logic [STRK_W-1:0] n_lt;
    logic [STRK_W-1:0] n_gt;
    logic [STRK_W-1:0] n_eq;
`endif

    modport master (
        output in_valid, a, b, sgn, out_ready,
        input  in_ready, out_valid, lt, gt, eq, streak
`ifdef CMP_STATS_EN
        , output stat_clr
        , input  n_lt, n_gt, n_eq
`endif
    );

    modport slave (
        input  in_valid, a, b, sgn, out_ready,
        output in_ready, out_valid, lt, gt, eq, streak
`ifdef CMP_STATS_EN
        , input  stat_clr
        , output n_lt, n_gt, n_eq
`endif
    );

endinterface

// File: rtl/cmp_core.sv
// Combinational magnitude compare of two WIDTH-bit operands.
// Signed mode flips both MSBs so an unsigned compare gives the two's-complement order.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output cmp_res_t         res
);

    logic [WIDTH-1:0] a_x;
    logic [WIDTH-1:0] b_x;

    // Bias operands for signed mode, then pick the one-hot result.
    always_comb begin
        a_x = a;
        b_x = b;
        if (sgn) begin
            a_x[WIDTH-1] = ~a[WIDTH-1];
            b_x[WIDTH-1] = ~b[WIDTH-1];
        end
        if (a_x < b_x) begin
            res = CMP_LT;
        end else if (a_x > b_x) begin
            res = CMP_GT;
        end else begin
            res = CMP_EQ;
        end
    end

endmodule

// File: rtl/cmp_stream_pipe.sv
// Two-stage streaming comparator: S1 holds the operand pair, S2 the one-hot
// result plus a saturating consecutive-equal streak. Whole pipe stalls together.
// Optional saturating result counters with clear are built when CMP_STATS_EN is defined.
module cmp_stream_pipe
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STRK_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    cmp_stream_pipe_if.slave bus
);

    logic              s1_v_q, s1_v_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sgn_q, sgn_d;
    logic              s2_v_q, s2_v_d;
    cmp_res_t          res_q, res_d;
    logic [STRK_W-1:0] streak_q, streak_d;

    cmp_res_t          core_res;
    logic              s2_adv;
    logic              in_ready;
    logic              s2_load;

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .a   (a_q),
        .b   (b_q),
        .sgn (sgn_q),
        .res (core_res)
    );

    // Handshake, stage advance and streak next-state.
    always_comb begin
        s2_adv   = !s2_v_q || bus.out_ready;
        in_ready = !s1_v_q || s2_adv;
        s2_load  = s2_adv && s1_v_q;

        s1_v_d   = s1_v_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        s2_v_d   = s2_v_q;
        res_d    = res_q;
        streak_d = streak_q;

        if (s2_adv) begin
            s2_v_d = s1_v_q;
        end
        if (s2_load) begin
            res_d = core_res;
            if (core_res == CMP_EQ) begin
                streak_d = STRK_W'(sat_inc(32'(streak_q), STRK_W));
            end else begin
                streak_d = '0;
            end
        end
        if (in_ready) begin
            s1_v_d = bus.in_valid;
            if (bus.in_valid) begin
                a_d   = bus.a;
                b_d   = bus.b;
                sgn_d = bus.sgn;
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            s2_v_q   <= 1'b0;
            res_q    <= CMP_NONE;
            streak_q <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            s2_v_q   <= s2_v_d;
            res_q    <= res_d;
            streak_q <= streak_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_v_q;
    assign bus.lt        = res_q[2];
    assign bus.gt        = res_q[1];
    assign bus.eq        = res_q[0];
    assign bus.streak    = streak_q;

`ifdef CMP_STATS_EN
    logic [STRK_W-1:0] n_lt_q, n_lt_d;
    logic [STRK_W-1:0] n_gt_q, n_gt_d;
    logic [STRK_W-1:0] n_eq_q, n_eq_d;

    // Result counters; a clear in the same cycle as a load drops that event.
    always_comb begin
        n_lt_d = n_lt_q;
        n_gt_d = n_gt_q;
        n_eq_d = n_eq_q;
        if (bus.stat_clr) begin
            n_lt_d = '0;
            n_gt_d = '0;
            n_eq_d = '0;
        end else if (s2_load) begin
            if (core_res == CMP_LT) n_lt_d = STRK_W'(sat_inc(32'(n_lt_q), STRK_W));
            if (core_res == CMP_GT) n_gt_d = STRK_W'(sat_inc(32'(n_gt_q), STRK_W));
            if (core_res == CMP_EQ) n_eq_d = STRK_W'(sat_inc(32'(n_eq_q), STRK_W));
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lt_q <= '0;
            n_gt_q <= '0;
            n_eq_q <= '0;
        end else begin
            n_lt_q <= n_lt_d;
            n_gt_q <= n_gt_d;
            n_eq_q <= n_eq_d;
        end
    end

    assign bus.n_lt = n_lt_q;
    assign bus.n_gt = n_gt_q;
    assign bus.n_eq = n_eq_q;
`endif

endmodule
